mem_port_arbiter: RTL and testbench

Shares the staged datapath's single unified memory port between the CPU (Stage1/Stage2 fetch and data accesses) and an external host/loader port used for program load and debug readback. Arbitration is fixed-priority to the CPU with a starvation guard for the host. Each access completes with a one-cycle ready/ack pulse. A `cpu_stall` output holds the control FSM while a CPU access is pending.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single unified memory port shared by the CPU and the host/loader.
// The CPU has fixed priority. The host wins once it has waited HOST_MAX_WAIT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int MEM_LAT       = 1,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  input  logic              host_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;

  localparam logic [7:0] MAX_WAIT   = 8'(HOST_MAX_WAIT);
  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
  localparam bit         SINGLE_LAT = (MEM_LAT == 1);

  state_t              state;
  owner_t              owner;
  logic                we_q;
  logic [2:0]          lat_cnt;
  logic [7:0]          wait_cnt;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   host_rdata_q;
  logic                host_win;
  logic                cpu_win;
  logic                host_busy;
  logic                read_done;

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    host_win  = 1'b0;
    cpu_win   = 1'b0;
    host_busy = (state != IDLE) && (owner == OWN_HOST);
    read_done = (state == DONE) && !we_q;
    if (state == IDLE) begin
      host_win = host_req && ((wait_cnt >= MAX_WAIT) || !cpu_req || host_hold);
      cpu_win  = !host_win && cpu_req && !host_hold;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ready;

  // Read data is valid on mem_rdata during DONE, so it is forwarded in that cycle and held from the register afterwards.
  always_comb begin
    cpu_rdata  = cpu_rdata_q;
    host_rdata = host_rdata_q;
    if (read_done && owner == OWN_CPU)  cpu_rdata  = mem_rdata;
    if (read_done && owner == OWN_HOST) host_rdata = mem_rdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= OWN_CPU;
      we_q         <= 1'b0;
      lat_cnt      <= '0;
      wait_cnt     <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      cpu_ready    <= 1'b0;
      host_ack     <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      cpu_ready <= 1'b0;
      host_ack  <= 1'b0;

      if (!host_req || host_win)
        wait_cnt <= '0;
      else if (!host_busy && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (host_win) begin
            owner     <= OWN_HOST;
            we_q      <= host_we;
            mem_en    <= 1'b1;
            mem_we    <= host_we;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
            state     <= ISSUE;
          end else if (cpu_win) begin
            owner     <= OWN_CPU;
            we_q      <= cpu_we;
            mem_en    <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_INIT;
          if (SINGLE_LAT) begin
            state     <= DONE;
            cpu_ready <= (owner == OWN_CPU);
            host_ack  <= (owner == OWN_HOST);
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            state     <= DONE;
            cpu_ready <= (owner == OWN_CPU);
            host_ack  <= (owner == OWN_HOST);
          end
        end
        DONE: begin
          if (!we_q && owner == OWN_CPU)  cpu_rdata_q  <= mem_rdata;
          if (!we_q && owner == OWN_HOST) host_rdata_q <= mem_rdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3.
// Each instance is backed by a small latency-accurate memory model.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        reset;

  // MEM_LAT = 1 instance
  logic        cpu_req, cpu_we, host_req, host_we, host_hold;
  logic [15:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic [15:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ready, cpu_stall, host_ack, mem_en, mem_we;

  // MEM_LAT = 3 instance
  logic        l3_cpu_req, l3_cpu_we, l3_host_req, l3_host_we, l3_host_hold;
  logic [15:0] l3_cpu_addr, l3_cpu_wdata, l3_host_addr, l3_host_wdata;
  logic [15:0] l3_cpu_rdata, l3_host_rdata, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;
  logic        l3_cpu_ready, l3_cpu_stall, l3_host_ack, l3_mem_en, l3_mem_we;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .HOST_MAX_WAIT(4)) dut (
    .CLK(CLK), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .host_hold(host_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .HOST_MAX_WAIT(4)) dut3 (
    .CLK(CLK), .reset(reset),
    .cpu_req(l3_cpu_req), .cpu_we(l3_cpu_we), .cpu_addr(l3_cpu_addr), .cpu_wdata(l3_cpu_wdata),
    .cpu_rdata(l3_cpu_rdata), .cpu_ready(l3_cpu_ready), .cpu_stall(l3_cpu_stall),
    .host_req(l3_host_req), .host_we(l3_host_we), .host_addr(l3_host_addr),
    .host_wdata(l3_host_wdata), .host_rdata(l3_host_rdata), .host_ack(l3_host_ack),
    .host_hold(l3_host_hold),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata)
  );

  // Memory models: data read in the mem_en cycle appears MEM_LAT cycles later.
  logic [15:0] mem1 [1024];
  logic [15:0] mem3 [1024];
  logic [15:0] rd1;
  logic [15:0] rd3 [3];

  always @(posedge CLK) begin
    if (!reset) begin
      mem1[16] <= 16'h1111;
    end else if (mem_en && mem_we) begin
      mem1[mem_addr[9:0]] <= mem_wdata;
    end
    if (mem_en && !mem_we) rd1 <= mem1[mem_addr[9:0]];
  end
  assign mem_rdata = rd1;

  always @(posedge CLK) begin
    if (!reset) begin
      mem3[512] <= 16'h1234;
      mem3[516] <= 16'h5678;
    end else if (l3_mem_en && l3_mem_we) begin
      mem3[l3_mem_addr[9:0]] <= l3_mem_wdata;
    end
    if (l3_mem_en && !l3_mem_we) rd3[0] <= mem3[l3_mem_addr[9:0]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign l3_mem_rdata = rd3[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One CPU access on the MEM_LAT=1 instance, requested while the arbiter is in IDLE.
  task automatic cpu_txn(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp_rd);
    int stalls;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    #1;
    stalls = int'(cpu_stall);
    step();
    check("cpu_issue_en_we", {30'd0, mem_en, mem_we}, {30'd0, 1'b1, we});
    check("cpu_issue_addr", mem_addr, addr);
    if (we) check("cpu_issue_wdata", mem_wdata, wd);
    check("cpu_ready_early", cpu_ready, 1'b0);
    stalls += int'(cpu_stall);
    step();
    check("cpu_ready_pulse", cpu_ready, 1'b1);
    check("cpu_rdata", cpu_rdata, exp_rd);
    check("cpu_done_mem_en", mem_en, 1'b0);
    stalls += int'(cpu_stall);
    check("cpu_stall_cycles", stalls, 2);
    cpu_req = 1'b0;
    step();
    check("cpu_ready_low", cpu_ready, 1'b0);
    check("cpu_rdata_held", cpu_rdata, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_pulse;
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_wdata = 16'h0; host_hold = 1'b0;
    l3_cpu_req = 1'b0; l3_cpu_we = 1'b0; l3_cpu_addr = 16'h0; l3_cpu_wdata = 16'h0;
    l3_host_req = 1'b0; l3_host_we = 1'b0; l3_host_addr = 16'h0; l3_host_wdata = 16'h0;
    l3_host_hold = 1'b0;

    // Reset held for two edges with a CPU request pending
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_strobes", {mem_en, mem_we, cpu_ready, host_ack}, 4'b0000);
      check("rst_mem_addr", mem_addr, 16'h0);
      check("rst_mem_wdata", mem_wdata, 16'h0);
      check("rst_rdata", {cpu_rdata, host_rdata}, 32'h0);
      check("rst_l3_stall_noreq", l3_cpu_stall, 1'b0);
    end
    reset = 1'b1;
    step();
    check("post_rst_grant_en", mem_en, 1'b1);
    check("post_rst_grant_addr", mem_addr, 16'h0010);
    step();
    check("post_rst_ready", cpu_ready, 1'b1);
    check("post_rst_rdata", cpu_rdata, 16'h1111);
    cpu_req = 1'b0;
    step();

    // CPU writes keep the previous read data; reads return the written value
    cpu_txn(1'b1, 16'h0010, 16'hBEEF, 16'h1111);
    cpu_txn(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    cpu_txn(1'b1, 16'h0011, 16'h0F0F, 16'hBEEF);
    cpu_txn(1'b0, 16'h0011, 16'h0000, 16'h0F0F);

    // Host write to 0x0020
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 16'h2222;
    step();
    check("host_wr_en_we", {mem_en, mem_we}, 2'b11);
    check("host_wr_addr", mem_addr, 16'h0020);
    step();
    check("host_wr_ack", {cpu_ready, host_ack}, 2'b01);
    host_req = 1'b0;
    step();

    // Both requesters held: CPU, CPU, host, repeating every 9 edges
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
    for (int i = 1; i <= 18; i++) begin
      step();
      exp_pulse = 2'b00;
      if (i == 2 || i == 5 || i == 11 || i == 14) exp_pulse = 2'b10;
      if (i == 8 || i == 17) exp_pulse = 2'b01;
      check($sformatf("contend_pulse_%0d", i), {cpu_ready, host_ack}, exp_pulse);
      if (i == 2) check("contend_cpu_rdata", cpu_rdata, 16'hBEEF);
      if (i == 6) check("contend_wait_6", dut.wait_cnt, 8'd6);
      if (i == 7) check("contend_wait_clear", dut.wait_cnt, 8'd0);
      if (i == 8) check("contend_host_rdata", host_rdata, 16'h2222);
    end
    cpu_req = 1'b0; host_req = 1'b0;
    step();

    // host_hold blocks new CPU grants but not one already in flight
    cpu_req = 1'b1; cpu_addr = 16'h0011; host_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_no_grant", mem_en, 1'b0);
      check("hold_stall", cpu_stall, 1'b1);
    end
    host_hold = 1'b0;
    step();
    check("hold_release_grant", mem_en, 1'b1);
    host_hold = 1'b1;
    step();
    check("hold_mid_access_ready", cpu_ready, 1'b1);
    check("hold_mid_access_rdata", cpu_rdata, 16'h0F0F);
    cpu_req = 1'b0; host_hold = 1'b0;
    step();

    // MEM_LAT=3 host read of 0x0200
    l3_host_req = 1'b1; l3_host_we = 1'b0; l3_host_addr = 16'h0200;
    step();
    check("l3_issue_en", {l3_mem_en, l3_mem_we}, 2'b10);
    check("l3_issue_addr", l3_mem_addr, 16'h0200);
    for (int i = 0; i < 2; i++) begin
      step();
      check("l3_wait_quiet", {l3_mem_en, l3_host_ack, l3_cpu_ready}, 3'b000);
    end
    step();
    check("l3_ack", {l3_host_ack, l3_cpu_ready}, 2'b10);
    check("l3_host_rdata", l3_host_rdata, 16'h1234);
    l3_host_req = 1'b0;
    step();
    check("l3_ack_low", l3_host_ack, 1'b0);
    check("l3_rdata_held", l3_host_rdata, 16'h1234);

    // Reset during WAIT of a host read aborts it
    l3_host_req = 1'b1; l3_host_addr = 16'h0204;
    step();
    check("l3_rst_issue", l3_mem_en, 1'b1);
    step();
    check("l3_rst_in_wait", {l3_mem_en, l3_host_ack}, 2'b00);
    reset = 1'b0;
    step();
    check("l3_rst_strobes", {l3_mem_en, l3_mem_we, l3_host_ack, l3_cpu_ready}, 4'b0000);
    check("l3_rst_rdata", {l3_host_rdata, l3_cpu_rdata}, 32'h0);
    check("l3_rst_addr", l3_mem_addr, 16'h0);
    l3_host_req = 1'b0; reset = 1'b1;
    step();
    check("l3_post_rst_no_ack", {l3_mem_en, l3_host_ack}, 2'b00);
    l3_host_req = 1'b1; l3_host_addr = 16'h0200;
    step();
    check("l3_post_rst_grant", l3_mem_en, 1'b1);
    step();
    step();
    step();
    check("l3_post_rst_ack", l3_host_ack, 1'b1);
    check("l3_post_rst_rdata", l3_host_rdata, 16'h1234);
    l3_host_req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
